uart_ns_tx_fifo: RTL and testbench



---
 rtl/uart_ns_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_ns_tx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ns_tx_fifo.sv
// rtl/uart_ns_tx_fifo.sv - buffered UART transmitter, 5-8 data bits, parity, 1/2 stop bits
// Optional line-break support is compiled in with UART_NS_TX_BREAK_EN.
module uart_ns_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [1:0]        data_bits_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    input  logic              two_stop_bits_i,
    input  logic              break_i,
    output logic              tx_pin_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  fifo_count_o,
    output logic              fifo_empty_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DIV_W-1:0]  div_q, baud_cnt, div_in;
    logic [2:0]        nbits_m1, bit_idx;
    logic [DATA_W-1:0] shreg, mask;
    logic              par_en_q, par_val_q, two_stop_q, stop_left, tx_q;
    logic              push, pop, bit_end, pop_block, force_low, line_next, par_in;

    assign div_in       = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
    assign bit_end      = (baud_cnt == '0);
    assign ready_o      = (count != CNT_W'(FIFO_DEPTH));
    assign push         = valid_i && ready_o;
    assign busy_o       = (state != IDLE);
    assign fifo_count_o = count;
    assign fifo_empty_o = (count == '0) && (state == IDLE);
    assign tx_pin_o     = tx_q;

`ifdef UART_NS_TX_BREAK_EN
    // Holds off new start bits for one full bit period after break releases.
    logic [DIV_W-1:0] hold_cnt;
    always_ff @(posedge clk) begin
        if (rst)                  hold_cnt <= '0;
        else if (break_i)         hold_cnt <= div_in;
        else if (hold_cnt != '0)  hold_cnt <= hold_cnt - DIV_W'(1);
    end
    assign pop_block = break_i || (hold_cnt != '0);
    assign force_low = break_i;
`else
    logic unused_break;
    assign unused_break = break_i;
    assign pop_block    = 1'b0;
    assign force_low    = 1'b0;
`endif

    // Parity over only the N bits that will actually be sent.
    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_W; i++) mask[i] = (i < int'(data_bits_i) + 5);
        par_in = (^(mem[rd_ptr] & mask)) ^ parity_odd_i;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (count != '0 && !pop_block) begin
                pop        = 1'b1;
                state_next = START;
            end
            START:  if (bit_end) state_next = DATA;
            DATA:   if (bit_end && bit_idx == nbits_m1) state_next = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) state_next = STOP;
            STOP: if (bit_end && !stop_left) begin
                if (count != '0 && !pop_block) begin
                    pop        = 1'b1;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = (state == DATA && bit_end) ? shreg[1] : shreg[0];
            PARITY:  line_next = par_val_q;
            default: line_next = 1'b1;
        endcase
        if (force_low) line_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_q       <= 1'b1;
            div_q      <= DIV_W'(1);
            baud_cnt   <= '0;
            nbits_m1   <= 3'd7;
            bit_idx    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_val_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_left  <= 1'b0;
        end else begin
            state <= state_next;
            tx_q  <= line_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);

            if (pop) begin
                div_q      <= div_in;
                baud_cnt   <= div_in - DIV_W'(1);
                shreg      <= mem[rd_ptr];
                nbits_m1   <= 3'd4 + {1'b0, data_bits_i};
                par_en_q   <= parity_en_i;
                par_val_q  <= par_in;
                two_stop_q <= two_stop_bits_i;
                bit_idx    <= '0;
                stop_left  <= 1'b0;
            end else if (state != IDLE) begin
                if (bit_end) begin
                    baud_cnt <= div_q - DIV_W'(1);
                    if (state == DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                    if (state_next == STOP && state != STOP) stop_left <= two_stop_q;
                    else if (state == STOP)                   stop_left <= 1'b0;
                end else begin
                    baud_cnt <= baud_cnt - DIV_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_ns_tx_fifo.sv
// tb/tb_uart_ns_tx_fifo.sv - scoreboard bench for uart_ns_tx_fifo
module tb_uart_ns_tx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] baud_div_i = 16'd4;
    logic [1:0]  data_bits_i = 2'b11;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        two_stop_bits_i = 1'b0;
    logic        break_i = 1'b0;
    logic        tx_pin_o;
    logic        busy_o;
    logic [3:0]  fifo_count_o;
    logic        fifo_empty_o;

    uart_ns_tx_fifo dut (
        .clk(clk), .rst(rst), .tx_data_i(tx_data_i), .valid_i(valid_i), .ready_o(ready_o),
        .baud_div_i(baud_div_i), .data_bits_i(data_bits_i), .parity_en_i(parity_en_i),
        .parity_odd_i(parity_odd_i), .two_stop_bits_i(two_stop_bits_i), .break_i(break_i),
        .tx_pin_o(tx_pin_o), .busy_o(busy_o), .fifo_count_o(fifo_count_o),
        .fifo_empty_o(fifo_empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lv;
        int          n;
        int          div;
        bit          b2b;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_busy = 1'b0;

    task automatic check(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic expect_frame(input logic [15:0] lv, input int n, input int div, input bit b2b);
        frame_t f;
        f.lv = lv; f.n = n; f.div = div; f.b2b = b2b;
        exp_q.push_back(f);
    endtask

    // Monitor: pops an expected frame and checks every clock of every bit on the line.
    initial begin : monitor
        frame_t f;
        int     t;
        bit     bad;
        int     act;
        forever begin
            if (exp_q.size() == 0) begin
                @(negedge clk);
                continue;
            end
            f = exp_q.pop_front();
            mon_busy = 1'b1;
            if (f.b2b) begin
                check(tx_pin_o == 1'b0, "b2b_start", int'(tx_pin_o), 0);
            end else begin
                t = 0;
                while (tx_pin_o !== 1'b0 && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 1000) begin
                    check(1'b0, "start_timeout", t, 1000);
                    mon_busy = 1'b0;
                    continue;
                end
            end
            for (int b = 0; b < f.n; b++) begin
                bad = 1'b0;
                act = int'(f.lv[b]);
                for (int k = 0; k < f.div; k++) begin
                    if (tx_pin_o !== f.lv[b] && !bad) begin
                        bad = 1'b1;
                        act = int'(tx_pin_o);
                    end
                    @(negedge clk);
                end
                check(!bad, $sformatf("frame_bit%0d", b), act, int'(f.lv[b]));
            end
            if (exp_q.size() == 0)
                check(busy_o == 1'b0 && fifo_empty_o == 1'b1, "busy_end", int'({busy_o, fifo_empty_o}), 1);
            mon_busy = 1'b0;
        end
    end

    task automatic cfg(input int div, input logic [1:0] db, input bit pe, input bit po, input bit ts);
        baud_div_i = 16'(div); data_bits_i = db; parity_en_i = pe;
        parity_odd_i = po; two_stop_bits_i = ts;
    endtask

    task automatic wr(input logic [7:0] d, output bit acc);
        valid_i = 1'b1;
        tx_data_i = d;
        acc = ready_o;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while (!(exp_q.size() == 0 && !mon_busy && fifo_empty_o) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(t < 3000, {nm, "_drain"}, t, 3000);
        check(busy_o == 1'b0 && ready_o == 1'b1 && fifo_count_o == 4'd0 && tx_pin_o == 1'b1,
              {nm, "_idle"}, int'({busy_o, ready_o, fifo_count_o, tx_pin_o}), 'b0_1_0000_1);
    endtask

    task automatic wait_low(output int t);
        t = 0;
        while (tx_pin_o !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(t < 500, "wait_low", t, 500);
    endtask

    initial begin : stim
        bit acc;
        int t;
        int prev;
        repeat (3) @(negedge clk);
        check(tx_pin_o == 1'b1, "rst_tx", int'(tx_pin_o), 1);
        check(ready_o == 1'b1, "rst_ready", int'(ready_o), 1);
        check(busy_o == 1'b0, "rst_busy", int'(busy_o), 0);
        check(fifo_count_o == 4'd0, "rst_count", int'(fifo_count_o), 0);
        check(fifo_empty_o == 1'b1, "rst_empty", int'(fifo_empty_o), 1);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 0x55 at 4 clocks per bit
        cfg(4, 2'b11, 0, 0, 0);
        expect_frame(16'b1010101010, 10, 4, 0);
        wr(8'h55, acc);
        wait_drain("8n1_55");

        // 7E1 / 7O1 0x07 at 2 clocks per bit
        cfg(2, 2'b10, 1, 0, 0);
        expect_frame(16'b1100001110, 10, 2, 0);
        wr(8'h07, acc);
        wait_drain("7e1");
        cfg(2, 2'b10, 1, 1, 0);
        expect_frame(16'b1000001110, 10, 2, 0);
        wr(8'h07, acc);
        wait_drain("7o1");

        // 5N2 0xFF, divisor 1 then divisor 0 (treated as 1)
        cfg(1, 2'b00, 0, 0, 1);
        expect_frame(16'b11111110, 8, 1, 0);
        wr(8'hFF, acc);
        wait_drain("5n2_div1");
        cfg(0, 2'b00, 0, 0, 1);
        expect_frame(16'b11111110, 8, 1, 0);
        wr(8'hFF, acc);
        wait_drain("5n2_div0");

        // Fill the FIFO while a frame is in flight; frames must run back-to-back
        cfg(3, 2'b11, 0, 0, 0);
        expect_frame({6'b0, 1'b1, 8'h81, 1'b0}, 10, 3, 0);
        wr(8'h81, acc);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) expect_frame({6'b0, 1'b1, 8'(i * 17), 1'b0}, 10, 3, 1);
            wr(8'(i * 17), acc);
            if (i == 9) check(acc == 1'b0, "full_reject", int'(acc), 0);
            else        check(acc == 1'b1, "fill_accept", int'(acc), 1);
        end
        check(fifo_count_o == 4'd8, "full_count", int'(fifo_count_o), 8);
        prev = 8;
        for (int p = 0; p < 8; p++) begin
            t = 0;
            while (int'(fifo_count_o) == prev && t < 100) begin
                @(negedge clk);
                t++;
            end
            check(int'(fifo_count_o) == prev - 1, "count_dec", int'(fifo_count_o), prev - 1);
            prev = prev - 1;
        end
        wait_drain("b2b");

        // Reset during the third data bit aborts cleanly
        cfg(4, 2'b11, 0, 0, 0);
        wr(8'hA5, acc);
        wait_low(t);
        repeat (13) @(negedge clk);
        check(busy_o == 1'b1, "mid_busy", int'(busy_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(tx_pin_o == 1'b1, "abort_tx", int'(tx_pin_o), 1);
        check(busy_o == 1'b0, "abort_busy", int'(busy_o), 0);
        check(fifo_count_o == 4'd0, "abort_count", int'(fifo_count_o), 0);
        check(fifo_empty_o == 1'b1, "abort_empty", int'(fifo_empty_o), 1);
        @(negedge clk);
        expect_frame(16'b1001111000, 10, 4, 0);
        wr(8'h3C, acc);
        wait_drain("post_rst");

`ifdef UART_NS_TX_BREAK_EN
        // Break mid-frame: line held low, next start delayed by at least one bit period
        begin
            bit lowbad;
            int high;
            cfg(4, 2'b11, 0, 0, 0);
            wr(8'hFF, acc);
            wait_low(t);
            repeat (6) @(negedge clk);
            break_i = 1'b1;
            @(negedge clk);
            wr(8'h00, acc);
            lowbad = 1'b0;
            for (int c = 0; c < 19; c++) begin
                if (tx_pin_o !== 1'b0) lowbad = 1'b1;
                @(negedge clk);
            end
            check(!lowbad, "break_low", int'(lowbad), 0);
            break_i = 1'b0;
            @(negedge clk);
            high = 0;
            while (tx_pin_o === 1'b1 && high < 200) begin
                @(negedge clk);
                high++;
            end
            check(high >= 4 && high < 200, "break_gap", high, 4);
            exp_q.delete();
            t = 0;
            while (!fifo_empty_o && t < 500) begin
                @(negedge clk);
                t++;
            end
            check(t < 500, "break_drain", t, 500);
        end
`else
        // Without break support, break_i must not disturb a frame (6O1 0x2A)
        cfg(2, 2'b01, 1, 1, 0);
        break_i = 1'b1;
        expect_frame(16'b101010100, 9, 2, 0);
        wr(8'h2A, acc);
        wait_drain("break_ignored");
        break_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
